// File: rtl/cic_decim_mc.sv
// Multi-channel CIC decimator control. Each tagged input sample advances its
// channel's phase counter and every dcef-th sample is forwarded with one cycle of latency.

module cic_decim_mc_ch #(
  parameter int CNT_W    = 8,
  parameter int DEF_DCEF = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             cfg_hit,
  input  logic [CNT_W-1:0] cfg_dcef,
  input  logic             clr,
  input  logic             smp,
  output logic             fire
);
  logic [CNT_W-1:0] dcef, cnt;
  logic             wrap;

  // dcef is never 0 (rejected at the config port), so dcef-1 cannot underflow.
  assign wrap = (cnt == dcef - CNT_W'(1));
  assign fire = smp && wrap && !cfg_hit && !clr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dcef <= CNT_W'(DEF_DCEF);
      cnt  <= '0;
    end else if (cfg_hit) begin
      dcef <= cfg_dcef;
      cnt  <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (smp) begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
    end
  end
endmodule

module cic_decim_mc #(
  parameter int DATA_W   = 37,
  parameter int NUM_CH   = 16,
  parameter int CH_W     = 4,
  parameter int CNT_W    = 8,
  parameter int DEF_DCEF = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              cfg_wr,
  input  logic              cfg_all,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_dcef,
  output logic              cfg_done,
  output logic              cfg_err,
  input  logic              sync_clr,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic [CH_W-1:0]   din_ch,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [CH_W-1:0]   dout_ch
);
  localparam logic [CH_W:0] NCH = (CH_W+1)'(NUM_CH);

  logic              cfg_ok, din_ok;
  logic [NUM_CH-1:0] fire;

  assign cfg_ok = cfg_wr && (|cfg_dcef) && (cfg_all || ({1'b0, cfg_ch} < NCH));
  assign din_ok = din_valid && ({1'b0, din_ch} < NCH);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    cic_decim_mc_ch #(.CNT_W(CNT_W), .DEF_DCEF(DEF_DCEF)) u_ch (
      .CLK      (CLK),
      .nRST     (nRST),
      .cfg_hit  (cfg_ok && (cfg_all || cfg_ch == CH_W'(c))),
      .cfg_dcef (cfg_dcef),
      .clr      (sync_clr),
      .smp      (din_ok && din_ch == CH_W'(c)),
      .fire     (fire[c])
    );
  end

  // At most one channel fires per cycle since only one sample arrives.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      dout_valid <= |fire;
      cfg_done   <= cfg_ok;
      cfg_err    <= cfg_wr && !cfg_ok;
      if (|fire) begin
        dout    <= din;
        dout_ch <= din_ch;
      end
    end
  end
endmodule

// File: tb/tb_cic_decim_mc.sv
// Directed bench for cic_decim_mc: a reference model pushes expected outputs
// into a queue as stimulus is driven; they are popped when dout_valid appears.

module tb_cic_decim_mc;
  localparam int DATA_W = 37, NUM_CH = 12, CH_W = 4, CNT_W = 8, DEF = 16;

  logic              CLK = 1'b0, nRST = 1'b0;
  logic              cfg_wr = 0, cfg_all = 0, sync_clr = 0, din_valid = 0;
  logic [CH_W-1:0]   cfg_ch = '0, din_ch = '0;
  logic [CNT_W-1:0]  cfg_dcef = '0;
  logic [DATA_W-1:0] din = '0;
  logic              cfg_done, cfg_err, dout_valid;
  logic [DATA_W-1:0] dout;
  logic [CH_W-1:0]   dout_ch;

  cic_decim_mc #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W), .DEF_DCEF(DEF)) dut (
    .CLK(CLK), .nRST(nRST), .cfg_wr(cfg_wr), .cfg_all(cfg_all), .cfg_ch(cfg_ch),
    .cfg_dcef(cfg_dcef), .cfg_done(cfg_done), .cfg_err(cfg_err), .sync_clr(sync_clr),
    .din(din), .din_valid(din_valid), .din_ch(din_ch),
    .dout(dout), .dout_valid(dout_valid), .dout_ch(dout_ch));

  always #5 CLK = ~CLK;

  typedef struct { longint d; int ch; } exp_t;
  exp_t   q[$];
  int     m_dcef[16], m_cnt[16];
  int     n_cmp = 0, n_err = 0, n_out = 0, base = 0;
  longint hold_d = 0;
  int     hold_ch = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 16; c++) begin m_dcef[c] = DEF; m_cnt[c] = 0; end
    q.delete();
    hold_d = 0; hold_ch = 0;
  endtask

  // Drive one cycle of stimulus, advance the model, then check after the edge.
  task automatic cyc(input bit v, input int ch, input longint d,
                     input bit cw = 0, input bit ca = 0, input int cc = 0,
                     input int cd = 0, input bit sc = 0);
    bit   ok, exp_v, hit;
    exp_t e;
    din_valid = v; din_ch = CH_W'(ch); din = DATA_W'(d);
    cfg_wr = cw; cfg_all = ca; cfg_ch = CH_W'(cc); cfg_dcef = CNT_W'(cd); sync_clr = sc;
    ok = cw && cd != 0 && (ca || cc < NUM_CH);
    exp_v = 0;
    if (v && ch < NUM_CH && !(ok && (ca || cc == ch)) && !sc && m_cnt[ch] == m_dcef[ch] - 1) begin
      exp_v = 1;
      q.push_back('{d, ch});
    end
    for (int c = 0; c < NUM_CH; c++) begin
      hit = ok && (ca || cc == c);
      if (hit) begin m_dcef[c] = cd; m_cnt[c] = 0; end
      else if (sc) m_cnt[c] = 0;
      else if (v && ch == c) m_cnt[c] = (m_cnt[c] == m_dcef[c] - 1) ? 0 : m_cnt[c] + 1;
    end
    @(posedge CLK); #1;
    chk("dout_valid", dout_valid, exp_v);
    chk("cfg_done", cfg_done, cw && ok);
    chk("cfg_err", cfg_err, cw && !ok);
    if (dout_valid) begin
      if (q.size() == 0) chk("spurious_out", dout_valid, 0);
      else begin
        e = q.pop_front();
        chk("dout", dout, e.d);
        chk("dout_ch", dout_ch, e.ch);
        hold_d = e.d; hold_ch = e.ch;
      end
      n_out++;
    end else begin
      chk("dout_hold", dout, hold_d);
      chk("dout_ch_hold", dout_ch, hold_ch);
    end
  endtask

  task automatic do_reset();
    din_valid = 0; cfg_wr = 0; sync_clr = 0;
    nRST = 0; #2;
    chk("rst_dout", dout, 0);
    chk("rst_dout_ch", dout_ch, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_err", cfg_err, 0);
    model_reset();
    @(posedge CLK); #1 nRST = 1;
  endtask

  initial begin
    model_reset();
    @(posedge CLK); #1;
    do_reset();

    // 32 samples on ch0 with default factor: outputs 16 and 32
    base = n_out;
    for (int i = 1; i <= 32; i++) cyc(1, 0, i);
    chk("n_out_ch0_def", n_out - base, 2);
    chk("last_ch0_def", hold_d, 32);

    // broadcast dcef=4, interleave ch0..ch3: each outputs its 4th and 8th sample
    cyc(0, 0, 0, 1, 1, 0, 4);
    base = n_out;
    for (int i = 1; i <= 8; i++)
      for (int c = 0; c < 4; c++) cyc(1, c, c * 100 + i);
    chk("n_out_interleave", n_out - base, 8);
    chk("last_interleave", hold_d, 308);

    // rejected writes: zero factor and out-of-range channel
    do_reset();
    cyc(0, 0, 0, 1, 0, 2, 0);
    cyc(0, 0, 0, 1, 0, 14, 5);
    base = n_out;
    for (int i = 1; i <= 16; i++) cyc(1, 2, 500 + i);
    chk("n_out_ch2_def", n_out - base, 1);
    cyc(0, 0, 0, 1, 0, 2, 3);
    base = n_out;
    for (int i = 1; i <= 9; i++) cyc(1, 2, 600 + i);
    chk("n_out_ch2_d3", n_out - base, 3);
    chk("last_ch2_d3", hold_d, 609);

    // out-of-range sample tag is ignored
    base = n_out;
    cyc(1, 13, 777);
    chk("n_out_bad_ch", n_out - base, 0);

    // config and sample on same channel: config wins, sample dropped
    base = n_out;
    cyc(1, 1, 800, 1, 0, 1, 2);
    cyc(1, 1, 801);
    chk("n_out_cfg_collide", n_out - base, 0);
    cyc(1, 1, 802);
    chk("n_out_after_collide", n_out - base, 1);
    chk("last_collide", hold_d, 802);

    // config and sample on different channels both take effect
    cyc(1, 1, 803, 1, 0, 3, 1);
    cyc(1, 3, 900);
    chk("last_ch3_d1", hold_d, 900);

    // sync_clr with coincident ch0 sample and ch5 config
    do_reset();
    for (int i = 1; i <= 10; i++) cyc(1, 0, i);
    base = n_out;
    cyc(1, 0, 11, 1, 0, 5, 1, 1);
    for (int i = 1; i <= 15; i++) cyc(1, 0, 20 + i);
    chk("n_out_sync_pre", n_out - base, 0);
    cyc(1, 0, 36);
    chk("n_out_sync_post", n_out - base, 1);
    chk("last_sync", hold_d, 36);
    for (int i = 1; i <= 3; i++) cyc(1, 5, 40 + i);
    chk("n_out_dcef1", n_out - base, 4);

    // reset mid-operation discards a just-produced output
    do_reset();
    for (int i = 1; i <= 15; i++) cyc(1, 0, i);
    din_valid = 1; din_ch = 0; din = DATA_W'(16);
    @(posedge CLK); #1 nRST = 0; #1;
    chk("midrst_valid", dout_valid, 0);
    chk("midrst_dout", dout, 0);
    model_reset();
    din_valid = 0;
    @(posedge CLK); #1 nRST = 1;
    base = n_out;
    cyc(1, 0, 99);
    chk("n_out_after_rst", n_out - base, 0);
    cyc(0, 0, 0);
    chk("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cic_decim_mc.md
CIC_DECIM_MC -- requirements
Module: cic_decim_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 37, sample width.
REQ-002 SHALL have parameter NUM_CH, default 16, channel count (1..16).
REQ-003 SHALL have parameter CH_W, default 4, channel index width.
REQ-004 SHALL have parameter CNT_W, default 8, decimation counter width.
REQ-005 SHALL have parameter DEF_DCEF, default 16, per-channel decimation factor after reset.
REQ-006 SHALL have port CLK  input  1  clock, all logic on rising edge.
REQ-007 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port cfg_wr  input  1  one-cycle config write strobe.
REQ-009 SHALL have port cfg_all  input  1  broadcast write to all channels when high with cfg_wr.
REQ-010 SHALL have port cfg_ch  input  CH_W  target channel of config write.
REQ-011 SHALL have port cfg_dcef  input  CNT_W  new decimation factor.
REQ-012 SHALL have port cfg_done  output  1  one-cycle pulse, write accepted.
REQ-013 SHALL have port cfg_err  output  1  one-cycle pulse, write rejected.
REQ-014 SHALL have port sync_clr  input  1  clears all phase counters, phase-aligns channels.
REQ-015 SHALL have ports din [DATA_W], din_valid [1], din_ch [CH_W], all inputs: input sample, qualifier, channel tag.
REQ-016 SHALL have ports dout [DATA_W], dout_valid [1], dout_ch [CH_W], all outputs: decimated sample, qualifier, channel tag.

Function
REQ-017 SHALL keep per channel a factor register dcef[c] and a phase counter cnt[c], CNT_W bits each.
REQ-018 SHALL be fully synchronous to CLK; no logic clocked by din_valid or any data signal.
REQ-019 On din_valid with cnt[din_ch]==dcef[din_ch]-1: SHALL register din/din_ch to dout/dout_ch, assert dout_valid next cycle, set cnt to 0.
REQ-020 On din_valid otherwise: SHALL increment cnt[din_ch]; dout_valid low next cycle.
REQ-021 Latency SHALL be exactly 1 cycle from accepted input to dout_valid; back-to-back inputs every cycle SHALL be supported.
REQ-022 dout/dout_ch SHALL hold their last value while dout_valid is low.
REQ-023 dcef=1 SHALL pass every sample; first output of channel c SHALL be its dcef[c]-th sample after reset/clear.
REQ-024 din_ch >= NUM_CH SHALL be ignored: no counter change, no output.
REQ-025 cfg_wr with cfg_dcef==0, or cfg_all low with cfg_ch>=NUM_CH, SHALL pulse cfg_err next cycle and change no state.
REQ-026 Valid cfg_wr SHALL load dcef for target channel(s), clear their cnt, and pulse cfg_done next cycle.
REQ-027 cfg_wr and din_valid same cycle on same channel: config SHALL win; sample dropped, cnt cleared, no output.
REQ-028 cfg_wr and din_valid on different channels same cycle: both SHALL take effect independently.
REQ-029 sync_clr SHALL clear all cnt next cycle; coincident din_valid sample dropped; coincident cfg_wr still applies dcef.
REQ-030 Lowering dcef below current cnt SHALL be harmless because the write clears cnt.

Reset
REQ-031 nRST low SHALL asynchronously set all dcef[c]=DEF_DCEF, all cnt[c]=0, dout=0, dout_ch=0, dout_valid=0, cfg_done=0, cfg_err=0.
REQ-032 Reset mid-operation SHALL discard pending output; first output after release follows REQ-023 with DEF_DCEF.

Verification
REQ-033 Reset, 32 samples ch0 values 1..32 -> dout_valid twice, dout=16 then 32, dout_ch=0, each 1 cycle after input.
REQ-034 Interleave ch0..ch3 every cycle, dcef via cfg_all=4 -> each channel outputs its 4th, 8th sample; no cross-channel count corruption.
REQ-035 cfg_wr ch2 dcef=0 -> cfg_err one cycle, ch2 still decimates by 16; cfg_wr ch2 dcef=3 -> cfg_done, outputs every 3rd ch2 sample.
REQ-036 cfg_wr ch1 dcef=2 same cycle as din_valid ch1 -> no output, next output on 2nd following ch1 sample.
REQ-037 Ch0 at cnt=10, sync_clr -> next ch0 output after 16 further samples; dcef=1 channel outputs every sample.
REQ-038 nRST pulse while cnt[0]=15 -> dout_valid=0, dout=0; next sample ch0 produces no output.
